// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit saturating counters,
// self-contained mispredict/redirect resolution and saturating statistics.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  pc_f,
  output logic             pred_taken_f,
  output logic [XLEN-1:0]  pred_target_f,
  input  logic             upd_valid_e,
  input  logic [XLEN-1:0]  upd_pc_e,
  input  logic             upd_jump_e,
  input  logic             upd_taken_e,
  input  logic [XLEN-1:0]  upd_target_e,
  input  logic             upd_pred_taken_e,
  input  logic [XLEN-1:0]  upd_pred_target_e,
  input  logic             invalidate,
  output logic             mispredict_e,
  output logic [XLEN-1:0]  redirect_pc_e,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  logic [ENTRIES-1:0] valid;
  logic [1:0]         ctr_mem    [ENTRIES];
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [XLEN-1:0]    target_mem [ENTRIES];

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit;
  logic             alloc, ctr_wr, tgt_wr;
  logic [1:0]       ctr_cur, ctr_next;

  // Fetch lookup reads registered state only, so an update to the same
  // index becomes visible one cycle later.
  assign f_idx         = pc_f[IDX_W+1:2];
  assign f_tag         = pc_f[IDX_W+TAG_W+1:IDX_W+2];
  assign f_hit         = valid[f_idx] && (tag_mem[f_idx] == f_tag);
  assign pred_taken_f  = f_hit && ctr_mem[f_idx][1];
  assign pred_target_f = pred_taken_f ? target_mem[f_idx] : pc_f + XLEN'(4);

  assign u_idx   = upd_pc_e[IDX_W+1:2];
  assign u_tag   = upd_pc_e[IDX_W+TAG_W+1:IDX_W+2];
  assign u_hit   = valid[u_idx] && (tag_mem[u_idx] == u_tag);
  assign ctr_cur = ctr_mem[u_idx];

  assign mispredict_e  = upd_valid_e &&
                         ((upd_taken_e != upd_pred_taken_e) ||
                          (upd_taken_e && (upd_pred_target_e != upd_target_e)));
  assign redirect_pc_e = upd_taken_e ? upd_target_e : upd_pc_e + XLEN'(4);

  // NOTE: every output of this block is given a default first so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    alloc    = 1'b0;
    ctr_wr   = 1'b0;
    tgt_wr   = 1'b0;
    ctr_next = ctr_cur;
    if (upd_valid_e && !invalidate) begin
      if (u_hit) begin
        ctr_wr = 1'b1;
        tgt_wr = upd_taken_e;
        if (upd_jump_e)
          ctr_next = CTR_STRONG_T;
        else if (upd_taken_e)
          ctr_next = (ctr_cur == CTR_STRONG_T) ? CTR_STRONG_T : ctr_cur + 2'd1;
        else
          ctr_next = (ctr_cur == CTR_STRONG_NT) ? CTR_STRONG_NT : ctr_cur - 2'd1;
      end else if (upd_taken_e) begin
        alloc    = 1'b1;
        ctr_wr   = 1'b1;
        tgt_wr   = 1'b1;
        ctr_next = upd_jump_e ? CTR_STRONG_T : CTR_WEAK_T;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_mem[i] <= CTR_WEAK_NT;
    end else begin
      if (invalidate)
        valid <= '0;
      else if (alloc)
        valid[u_idx] <= 1'b1;
      if (ctr_wr) ctr_mem[u_idx] <= ctr_next;
    end
  end

  // NOTE: tags and targets are qualified by valid, so this storage is
  // deliberately left without reset.
  always_ff @(posedge clk) begin
    if (alloc)  tag_mem[u_idx]    <= u_tag;
    if (tgt_wr) target_mem[u_idx] <= upd_target_e;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (upd_valid_e && !(&branch_count))
        branch_count <= branch_count + CNT_W'(1);
      if (mispredict_e && !(&mispredict_count))
        mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: stimulus pushes expected responses
// into a scoreboard queue, a negedge monitor pops and compares them.
module tb_branch_predictor;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int TAG_W   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic [XLEN-1:0]  pc_f;
  logic             pred_taken_f;
  logic [XLEN-1:0]  pred_target_f;
  logic             upd_valid_e;
  logic [XLEN-1:0]  upd_pc_e;
  logic             upd_jump_e;
  logic             upd_taken_e;
  logic [XLEN-1:0]  upd_target_e;
  logic             upd_pred_taken_e;
  logic [XLEN-1:0]  upd_pred_target_e;
  logic             invalidate;
  logic             mispredict_e;
  logic [XLEN-1:0]  redirect_pc_e;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  branch_predictor #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .pc_f(pc_f), .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
    .upd_valid_e(upd_valid_e), .upd_pc_e(upd_pc_e), .upd_jump_e(upd_jump_e),
    .upd_taken_e(upd_taken_e), .upd_target_e(upd_target_e),
    .upd_pred_taken_e(upd_pred_taken_e), .upd_pred_target_e(upd_pred_target_e),
    .invalidate(invalidate), .mispredict_e(mispredict_e),
    .redirect_pc_e(redirect_pc_e), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        pt;
    logic [31:0] ptgt;
    logic        chk_redir;
    logic        mp;
    logic [31:0] rpc;
    int          bc;
    int          mc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   exp_bc = 0;
  int   exp_mc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check({mon_e.name, ".pred_taken"}, 32'(pred_taken_f), 32'(mon_e.pt));
      check({mon_e.name, ".pred_target"}, pred_target_f, mon_e.ptgt);
      check({mon_e.name, ".mispredict"}, 32'(mispredict_e), 32'(mon_e.mp));
      if (mon_e.chk_redir)
        check({mon_e.name, ".redirect"}, redirect_pc_e, mon_e.rpc);
      check({mon_e.name, ".branch_count"}, 32'(branch_count), 32'(mon_e.bc));
      check({mon_e.name, ".mispredict_count"}, 32'(mispredict_count), 32'(mon_e.mc));
    end
  end

  // One cycle of stimulus plus its hand-computed expected response.
  task automatic vec(input string name, input logic [31:0] pc,
                     input bit uv, input logic [31:0] upc, input bit jump,
                     input bit taken, input logic [31:0] tgt,
                     input bit ptk, input logic [31:0] ptg, input bit inv,
                     input bit ept, input logic [31:0] eptg,
                     input bit emp, input logic [31:0] erpc);
    exp_t e;
    @(posedge clk);
    #1;
    pc_f              = pc;
    upd_valid_e       = uv;
    upd_pc_e          = upc;
    upd_jump_e        = jump;
    upd_taken_e       = taken;
    upd_target_e      = tgt;
    upd_pred_taken_e  = ptk;
    upd_pred_target_e = ptg;
    invalidate        = inv;
    e.name      = name;
    e.pt        = ept;
    e.ptgt      = eptg;
    e.chk_redir = uv;
    e.mp        = emp;
    e.rpc       = erpc;
    e.bc        = exp_bc;
    e.mc        = exp_mc;
    sb.push_back(e);
    if (uv && exp_bc < CNT_MAX) exp_bc++;
    if (emp && exp_mc < CNT_MAX) exp_mc++;
  endtask

  task automatic look(input string name, input logic [31:0] pc,
                      input bit ept, input logic [31:0] eptg);
    vec(name, pc, 0, 0, 0, 0, 0, 0, 0, 0, ept, eptg, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    pc_f = 32'h100; upd_valid_e = 0; upd_pc_e = 0; upd_jump_e = 0;
    upd_taken_e = 0; upd_target_e = 0; upd_pred_taken_e = 0;
    upd_pred_target_e = 0; invalidate = 0;

    look("reset_lookup", 32'h100, 0, 32'h104);
    @(negedge clk); #1 reset = 1'b1;

    // Allocate on taken miss; same-cycle lookup sees the old state.
    vec("alloc", 32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 32'h104, 0, 0, 32'h104, 1, 32'h80);
    look("alloc_hit", 32'h100, 1, 32'h80);
    // Hysteresis 10 -> 01 -> 00 -> 01 -> 10.
    vec("nt1", 32'h100, 1, 32'h100, 0, 0, 32'h80, 1, 32'h80, 0, 1, 32'h80, 1, 32'h104);
    look("after_nt1", 32'h100, 0, 32'h104);
    vec("nt2", 32'h100, 1, 32'h100, 0, 0, 32'h80, 0, 32'h104, 0, 0, 32'h104, 0, 32'h104);
    vec("t1", 32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 32'h104, 0, 0, 32'h104, 1, 32'h80);
    vec("t2", 32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 32'h104, 0, 0, 32'h104, 1, 32'h80);
    look("after_t2", 32'h100, 1, 32'h80);
    // Long taken run must saturate at 11, so one not-taken leaves it taken.
    for (int i = 0; i < 300; i++)
      vec("taken_run", 32'h100, 1, 32'h100, 0, 1, 32'h80, 1, 32'h80, 0, 1, 32'h80, 0, 32'h80);
    vec("nt_after_run", 32'h100, 1, 32'h100, 0, 0, 32'h80, 1, 32'h80, 0, 1, 32'h80, 1, 32'h104);
    look("still_taken", 32'h100, 1, 32'h80);
    // Alias at 0x100 + 4*ENTRIES replaces the entry.
    vec("alias", 32'h100, 1, 32'h140, 0, 1, 32'h200, 0, 32'h144, 0, 1, 32'h80, 1, 32'h200);
    look("alias_old_miss", 32'h100, 0, 32'h104);
    look("alias_new_hit", 32'h140, 1, 32'h200);
    // Wrong target.
    vec("wrong_tgt", 32'h140, 1, 32'h140, 0, 1, 32'h90, 1, 32'h80, 0, 1, 32'h200, 1, 32'h90);
    look("new_tgt", 32'h140, 1, 32'h90);
    // Jump allocates strong-taken: one not-taken still predicts taken.
    vec("jump", 32'h20, 1, 32'h20, 1, 1, 32'h400, 0, 32'h24, 0, 0, 32'h24, 1, 32'h400);
    vec("jump_nt", 32'h20, 1, 32'h20, 0, 0, 32'h400, 1, 32'h400, 0, 1, 32'h400, 1, 32'h24);
    look("jump_still_t", 32'h20, 1, 32'h400);

    // Asynchronous reset mid-cycle: counters clear before the next edge.
    begin
      exp_t e;
      @(posedge clk);
      #3;
      pc_f = 32'h20; upd_valid_e = 0; invalidate = 0;
      reset = 1'b0;
      e.name = "async_reset"; e.pt = 0; e.ptgt = 32'h24; e.chk_redir = 0;
      e.mp = 0; e.rpc = 0; e.bc = 0; e.mc = 0;
      sb.push_back(e);
      exp_bc = 0; exp_mc = 0;
      @(negedge clk); #1 reset = 1'b1;
    end

    // Invalidate wins over allocation, statistics still count.
    vec("inv_alloc", 32'h300, 1, 32'h300, 0, 1, 32'h10, 0, 32'h304, 1, 0, 32'h304, 1, 32'h10);
    look("inv_alloc_miss", 32'h300, 0, 32'h304);
    vec("alloc2", 32'h140, 1, 32'h140, 0, 1, 32'h200, 0, 32'h144, 0, 0, 32'h144, 1, 32'h200);
    vec("inv_only", 32'h140, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h200, 0, 0);
    look("inv_cleared", 32'h140, 0, 32'h144);

    // Statistics saturation with a 4-bit counter.
    for (int i = 0; i < 20; i++)
      vec("sat_run", 32'h500, 1, 32'h100, 0, 1, 32'h80, 0, 32'h104, 0, 0, 32'h504, 1, 32'h80);
    look("sat_final", 32'h100, 1, 32'h80);
    if (exp_bc != CNT_MAX || exp_mc != CNT_MAX)
      $display("FAIL sat_model: got %0d/%0d, expected 15/15", exp_bc, exp_mc);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the pipelined RV32I core: a direct-mapped branch target buffer (BTB) plus a 2-bit saturating-counter table. It predicts next-PC in Fetch and is trained in Execute. It resolves mispredictions itself and drives the corrected redirect PC, replacing the static "predict not-taken, flush on PCSrcE" scheme. It also keeps saturating branch and mispredict statistics counters for performance runs.

## Interface
- XLEN, 32: address/data width.
- ENTRIES, 16: BTB/counter entries; power of two, ≥ 2. IDX_W = log2(ENTRIES).
- TAG_W, 8: stored tag bits; IDX_W + TAG_W + 2 ≤ XLEN.
- CNT_W, 32: width of statistics counters.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 resets all state immediately.
- pc_f  in  XLEN  fetch PC to predict.
- pred_taken_f  out  1  prediction for pc_f is taken.
- pred_target_f  out  XLEN  predicted next PC (stored target if taken, else pc_f + 4).
- upd_valid_e  in  1  resolved branch/jump in Execute this cycle.
- upd_pc_e  in  XLEN  PC of the resolved instruction.
- upd_jump_e  in  1  instruction is an unconditional jump.
- upd_taken_e  in  1  actual outcome (PCSrcE).
- upd_target_e  in  XLEN  actual target (PCTargetE).
- upd_pred_taken_e  in  1  prediction carried down the pipe with the instruction.
- upd_pred_target_e  in  XLEN  predicted next PC carried down the pipe.
- invalidate  in  1  synchronous clear of all BTB valid bits (fence.i).
- mispredict_e  out  1  redirect required; core flushes D and E.
- redirect_pc_e  out  XLEN  correct next PC.
- branch_count  out  CNT_W  resolved updates seen.
- mispredict_count  out  CNT_W  mispredicts seen.

## Operation
- Index = PC[IDX_W+1:2]. Tag = PC[IDX_W+TAG_W+1:IDX_W+2].
- Each entry holds valid, tag, target[XLEN], and a 2-bit counter ctr: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup:
  - hit = valid[idx] && tag matches.
  - pred_taken_f = hit && ctr[1].
  - pred_target_f = pred_taken_f ? target : pc_f + 4. Addition wraps modulo 2^XLEN.
- Mispredict, only when upd_valid_e=1:
  - mispredict_e = (upd_taken_e != upd_pred_taken_e) || (upd_taken_e && upd_pred_target_e != upd_target_e).
  - If upd_valid_e=0, mispredict_e = 0.
- redirect_pc_e = upd_taken_e ? upd_target_e : upd_pc_e + 4. It is combinational and meaningful only when mispredict_e=1.
- Training on upd_valid_e=1, with entry selected by upd_pc_e:
  - Hit, taken: ctr saturating +1 (11 stays 11); target ← upd_target_e.
  - Hit, not taken: ctr saturating −1 (00 stays 00); target unchanged.
  - Miss, taken: allocate. valid←1, tag, target←upd_target_e, ctr←10. This overwrites any aliased entry.
  - Miss, not taken: no change.
  - upd_jump_e=1 (always taken): ctr←11 on hit or allocate.
- Statistics:
  - branch_count +1 per upd_valid_e cycle.
  - mispredict_count +1 per mispredict_e cycle.
  - Both saturate at all-ones and never wrap.
- invalidate=1: all valid←0 at the edge; counters and targets are kept.
  - invalidate together with upd_valid_e: invalidate wins and any allocation is dropped.
  - Statistics still count in that cycle.

## Timing
- Lookup is combinational from registered state, zero latency, same cycle as pc_f.
- Training takes effect at the rising edge ending the update cycle.
- If Fetch looks up the same index in the same cycle as an update, it sees the pre-update state (no bypass). It sees the new state from the next cycle on.
- mispredict_e and redirect_pc_e are combinational in the update cycle. The core loads redirect_pc_e into PCF at that edge.
- Reset (reset=0, asynchronous, also mid-operation):
  - All valid=0; every ctr=01; targets/tags don't-care.
  - branch_count = mispredict_count = 0.
  - Outputs immediately: pred_taken_f=0, pred_target_f=pc_f+4, mispredict_e=0 unless an update is presented.
- On reset release, the first edge with reset=1 operates normally.

## Test plan
- Reset then lookup: pc_f=0x100 → pred_taken_f=0, pred_target_f=0x104; both stat counters 0.
- Taken branch allocate:
  - upd pc=0x100, taken=1, target=0x80, pred_taken=0 → mispredict_e=1, redirect_pc_e=0x80.
  - Next cycle, pc_f=0x100 → pred_taken_f=1, pred_target_f=0x80.
- Counter hysteresis, from allocated ctr=10:
  - Two not-taken updates at 0x100: first → ctr 01, prediction NT; second → 00.
  - Then one taken → 01, still NT. Another taken → 10, T.
  - 300 taken updates → ctr stays 11.
- Aliasing and wrong target:
  - 0x100 entry present; taken update at 0x100+4·ENTRIES with different tag → entry replaced, lookup 0x100 misses.
  - Predicted taken with target 0x80 but actual 0x90 → mispredict_e=1, redirect 0x90.
- Simultaneous events:
  - invalidate and taken-miss update in the same cycle → no entry valid afterwards; branch_count still +1.
  - Lookup at the same index as an update shows the old prediction that cycle.
- Saturation and async reset:
  - CNT_W=4: 20 mispredicting updates → both counters hold 15.
  - Drop reset mid-cycle → counters read 0 before the next edge.
